// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, writeback-source codes and FSM encodings for the pipeline
// hazard controller.
package hazard_ctrl_pkg;

  localparam int REGADDR_WIDTH = 5;
  typedef logic [REGADDR_WIDTH-1:0] regaddr_t;

  localparam int WB_SRC_WIDTH = 2;
  localparam logic [WB_SRC_WIDTH-1:0] WB_SRC_ALU = 2'd0;
  localparam logic [WB_SRC_WIDTH-1:0] WB_SRC_MEM = 2'd1;

  localparam int HZ_STATE_WIDTH = 2;
  localparam logic [HZ_STATE_WIDTH-1:0] HZ_RUN        = 2'd0;
  localparam logic [HZ_STATE_WIDTH-1:0] HZ_LOAD_STALL = 2'd1;
  localparam logic [HZ_STATE_WIDTH-1:0] HZ_MEM_WAIT   = 2'd2;

  typedef struct packed {
    logic pc_stall;
    logic if2id_stall;
    logic if2id_flush;
    logic id2ex_bubble;
    logic ex2mem_stall;
    logic mem2wb_bubble;
    logic muldiv_busy;
    logic mem_timeout;
  } hz_ctrl_t;

  // r0 is hardwired to zero, so it can never carry a real dependency.
  function automatic logic src_hit(input logic uses, input regaddr_t src,
                                   input regaddr_t dst);
    return uses && (dst != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: ID/EX/MEM status in,
// stage enable/clear controls out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  regaddr_t                id_rs_addr;
  regaddr_t                id_rt_addr;
  logic                    id_uses_rs;
  logic                    id_uses_rt;
  logic                    id_is_muldiv;
  logic                    id_reads_hilo;
  regaddr_t                id2ex_wb_reg_addr;
  logic [WB_SRC_WIDTH-1:0] id2ex_wb_src;
  logic                    ex_branch_taken;
  logic                    mem_req;
  logic                    mem_ack;

  logic pc_stall;
  logic if2id_stall;
  logic if2id_flush;
  logic id2ex_bubble;
  logic ex2mem_stall;
  logic mem2wb_bubble;
  logic muldiv_busy;
  logic mem_timeout;

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_muldiv,
           id_reads_hilo, id2ex_wb_reg_addr, id2ex_wb_src, ex_branch_taken,
           mem_req, mem_ack,
    input  pc_stall, if2id_stall, if2id_flush, id2ex_bubble, ex2mem_stall,
           mem2wb_bubble, muldiv_busy, mem_timeout
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_muldiv,
           id_reads_hilo, id2ex_wb_reg_addr, id2ex_wb_src, ex_branch_taken,
           mem_req, mem_ack,
    output pc_stall, if2id_stall, if2id_flush, id2ex_bubble, ex2mem_stall,
           mem2wb_bubble, muldiv_busy, mem_timeout
  );

endinterface

// File: rtl/hazard_ctrl_muldiv_tracker.sv
// Mul/div occupancy tracker: down-counter loaded on issue, busy flag and
// ID-stage stall for instructions that need the unit or its HI/LO result.
module hazard_ctrl_muldiv_tracker #(
  parameter int MULDIV_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic is_muldiv_i,
  input  logic reads_hilo_i,
  input  logic id_hold_i,
  output logic busy_o,
  output logic stall_o
);

  localparam int CW = $clog2(MULDIV_CYCLES + 1);

  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          free;
  logic          issue;

  // The final busy cycle (count 1) already frees the unit: the result is
  // ready and a new operation may issue that same cycle.
  always_comb begin
    free     = (md_cnt_q <= CW'(1));
    issue    = free && is_muldiv_i && !id_hold_i;
    busy_o   = (md_cnt_q != '0);
    stall_o  = !free && (is_muldiv_i || reads_hilo_i);
    md_cnt_d = md_cnt_q;
    if (issue) begin
      md_cnt_d = CW'(MULDIV_CYCLES);
    end else if (busy_o) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, bubbles and flushes the 5-stage core
// for memory waits, taken branches, mul/div occupancy and load-use hazards.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 2,
  parameter int MULDIV_CYCLES  = 8,
  parameter int MEM_TIMEOUT    = 255
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int LW = (LOAD_USE_STALL > 1) ? $clog2(LOAD_USE_STALL) : 1;
  localparam logic [LW-1:0] LD_INIT   = LW'(LOAD_USE_STALL - 1);
  localparam logic [7:0]    WAIT_TOP  = 8'(MEM_TIMEOUT);
  localparam logic [7:0]    WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [HZ_STATE_WIDTH-1:0] state_q, state_d;
  logic [HZ_STATE_WIDTH-1:0] ret_q, ret_d;
  logic [LW-1:0]             ld_cnt_q, ld_cnt_d;
  logic [7:0]                wait_q, wait_d;
  logic                      timeout_q, timeout_d;

  logic     mem_stall;
  logic     branch;
  logic     load_hit;
  logic     ld_stall;
  logic     id_hold;
  logic     md_busy;
  logic     md_stall;
  hz_ctrl_t ctrl;

  assign mem_stall = hz.mem_req && !hz.mem_ack;
  assign branch    = hz.ex_branch_taken && !mem_stall;
  assign load_hit  = (hz.id2ex_wb_src == WB_SRC_MEM) &&
                     (src_hit(hz.id_uses_rs, hz.id_rs_addr, hz.id2ex_wb_reg_addr) ||
                      src_hit(hz.id_uses_rt, hz.id_rt_addr, hz.id2ex_wb_reg_addr));
  assign ld_stall  = (state_q == HZ_LOAD_STALL) || ((state_q == HZ_RUN) && load_hit);
  assign id_hold   = mem_stall || branch || ld_stall;

  hazard_ctrl_muldiv_tracker #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_muldiv_tracker (
    .clk         (clk),
    .rst         (rst),
    .is_muldiv_i (hz.id_is_muldiv),
    .reads_hilo_i(hz.id_reads_hilo),
    .id_hold_i   (id_hold),
    .busy_o      (md_busy),
    .stall_o     (md_stall)
  );

  always_comb begin
    ctrl = '0;
    if (mem_stall) begin
      ctrl.pc_stall      = 1'b1;
      ctrl.if2id_stall   = 1'b1;
      ctrl.ex2mem_stall  = 1'b1;
      ctrl.mem2wb_bubble = 1'b1;
    end else if (branch) begin
      ctrl.if2id_flush  = 1'b1;
      ctrl.id2ex_bubble = 1'b1;
    end else if (md_stall || ld_stall) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if2id_stall  = 1'b1;
      ctrl.id2ex_bubble = 1'b1;
    end
    ctrl.muldiv_busy = md_busy;
    ctrl.mem_timeout = timeout_q;
    if (rst) begin
      ctrl = '0;
    end
  end

  assign hz.pc_stall      = ctrl.pc_stall;
  assign hz.if2id_stall   = ctrl.if2id_stall;
  assign hz.if2id_flush   = ctrl.if2id_flush;
  assign hz.id2ex_bubble  = ctrl.id2ex_bubble;
  assign hz.ex2mem_stall  = ctrl.ex2mem_stall;
  assign hz.mem2wb_bubble = ctrl.mem2wb_bubble;
  assign hz.muldiv_busy   = ctrl.muldiv_busy;
  assign hz.mem_timeout   = ctrl.mem_timeout;

  // During MEM_WAIT the load counter is left untouched, so it doubles as
  // the saved copy restored when the bus access completes.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    ld_cnt_d  = ld_cnt_q;
    wait_d    = '0;
    timeout_d = timeout_q;
    if (mem_stall) begin
      state_d = HZ_MEM_WAIT;
      if (state_q != HZ_MEM_WAIT) begin
        ret_d = state_q;
      end else begin
        wait_d = (wait_q == WAIT_TOP) ? wait_q : wait_q + 8'd1;
        if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
        end
      end
    end else if (branch) begin
      state_d  = HZ_RUN;
      ld_cnt_d = '0;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (load_hit && (LOAD_USE_STALL > 1)) begin
            state_d  = HZ_LOAD_STALL;
            ld_cnt_d = LD_INIT;
          end
        end
        HZ_LOAD_STALL: begin
          if (ld_cnt_q <= LW'(1)) begin
            state_d  = HZ_RUN;
            ld_cnt_d = '0;
          end else begin
            ld_cnt_d = ld_cnt_q - LW'(1);
          end
        end
        default: state_d = ret_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HZ_RUN;
      ret_q     <= HZ_RUN;
      ld_cnt_q  <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      ld_cnt_q  <= ld_cnt_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle vector table plus hand-written
// timeout and reset-during-wait sequences.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  typedef struct {
    regaddr_t                rs;
    regaddr_t                rt;
    logic                    urs;
    logic                    urt;
    logic                    is_md;
    logic                    hilo;
    regaddr_t                ex_rd;
    logic [WB_SRC_WIDTH-1:0] ex_src;
    logic                    br;
    logic                    req;
    logic                    ack;
    logic [7:0]              exp;
    string                   name;
  } vec_t;

  // Expected-output bit order:
  // {pc_stall, if2id_stall, if2id_flush, id2ex_bubble,
  //  ex2mem_stall, mem2wb_bubble, muldiv_busy, mem_timeout}
  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_ID    = 8'hD0;
  localparam logic [7:0] O_MEMW  = 8'hCC;
  localparam logic [7:0] O_FLUSH = 8'h30;
  localparam logic [7:0] O_BUSY  = 8'h02;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .LOAD_USE_STALL(2),
    .MULDIV_CYCLES (8),
    .MEM_TIMEOUT   (255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  function automatic vec_t v_idle();
    vec_t v;
    v.rs = '0; v.rt = '0; v.urs = 1'b0; v.urt = 1'b0;
    v.is_md = 1'b0; v.hilo = 1'b0;
    v.ex_rd = '0; v.ex_src = WB_SRC_ALU;
    v.br = 1'b0; v.req = 1'b0; v.ack = 1'b0;
    v.exp = '0; v.name = "";
    return v;
  endfunction

  function automatic vec_t v_ld(input regaddr_t rd, input regaddr_t rs, input logic urs,
                                input regaddr_t rt, input logic urt);
    vec_t v = v_idle();
    v.ex_rd = rd; v.ex_src = WB_SRC_MEM;
    v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
    return v;
  endfunction

  function automatic vec_t v_mem(input logic req, input logic ack);
    vec_t v = v_idle();
    v.req = req; v.ack = ack;
    return v;
  endfunction

  function automatic vec_t v_md(input logic is_md, input logic hilo);
    vec_t v = v_idle();
    v.is_md = is_md; v.hilo = hilo;
    return v;
  endfunction

  function automatic vec_t v_br();
    vec_t v = v_idle();
    v.br = 1'b1;
    return v;
  endfunction

  task automatic push(input vec_t v, input logic [7:0] exp, input string name, input int n = 1);
    for (int k = 0; k < n; k++) begin
      v.exp  = exp;
      v.name = (n > 1) ? $sformatf("%s_%0d", name, k) : name;
      vecs.push_back(v);
    end
  endtask

  task automatic apply(input vec_t v);
    hz.id_rs_addr        = v.rs;
    hz.id_rt_addr        = v.rt;
    hz.id_uses_rs        = v.urs;
    hz.id_uses_rt        = v.urt;
    hz.id_is_muldiv      = v.is_md;
    hz.id_reads_hilo     = v.hilo;
    hz.id2ex_wb_reg_addr = v.ex_rd;
    hz.id2ex_wb_src      = v.ex_src;
    hz.ex_branch_taken   = v.br;
    hz.mem_req           = v.req;
    hz.mem_ack           = v.ack;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {hz.pc_stall, hz.if2id_stall, hz.if2id_flush, hz.id2ex_bubble,
           hz.ex2mem_stall, hz.mem2wb_bubble, hz.muldiv_busy, hz.mem_timeout};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic cycle(input vec_t v, input logic [7:0] exp, input string name);
    apply(v);
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;

    // Load-use on rs and rt, and cases that must not stall.
    push(v_idle(), O_NONE, "idle");
    push(v_ld(5'd3, 5'd3, 1'b1, 5'd0, 1'b0), O_ID, "lu_rs3_detect");
    push(v_idle(), O_ID, "lu_rs3_hold");
    push(v_idle(), O_NONE, "lu_rs3_release");
    push(v_ld(5'd0, 5'd0, 1'b1, 5'd0, 1'b1), O_NONE, "lu_r0");
    push(v_ld(5'd7, 5'd1, 1'b1, 5'd7, 1'b1), O_ID, "lu_rt7_detect");
    push(v_idle(), O_ID, "lu_rt7_hold");
    push(v_idle(), O_NONE, "lu_rt7_release");
    push(v_ld(5'd5, 5'd5, 1'b0, 5'd9, 1'b1), O_NONE, "lu_rs_unused");
    v = v_ld(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    v.ex_src = WB_SRC_ALU;
    push(v, O_NONE, "alu_src_forwarded");

    // Memory wait, release on ack, and same-cycle req/ack.
    push(v_mem(1'b1, 1'b0), O_MEMW, "memw", 4);
    push(v_mem(1'b1, 1'b1), O_NONE, "memw_ack");
    push(v_idle(), O_NONE, "memw_after");
    push(v_mem(1'b1, 1'b1), O_NONE, "mem_req_ack");

    // Branch flush, and memory wait outranking it.
    push(v_br(), O_FLUSH, "branch");
    push(v_idle(), O_NONE, "branch_after");
    v = v_br();
    v.req = 1'b1;
    push(v, O_MEMW, "branch_under_memw");
    push(v_mem(1'b1, 1'b1), O_NONE, "branch_memw_ack");

    // Branch in the first LOAD_STALL cycle aborts the load stall.
    push(v_ld(5'd3, 5'd3, 1'b1, 5'd0, 1'b0), O_ID, "bra_detect");
    push(v_br(), O_FLUSH, "bra_flush");
    push(v_idle(), O_NONE, "bra_run");

    // Mul/div issue then HI/LO read.
    push(v_md(1'b1, 1'b0), O_NONE, "md_issue");
    push(v_md(1'b0, 1'b1), O_ID | O_BUSY, "md_hilo_stall", 7);
    push(v_md(1'b0, 1'b1), O_BUSY, "md_release");
    push(v_idle(), O_NONE, "md_idle");

    // Back-to-back mul/div: second issues on the release cycle.
    push(v_md(1'b1, 1'b0), O_NONE, "md2_issue");
    push(v_md(1'b1, 1'b0), O_ID | O_BUSY, "md2_stall", 7);
    push(v_md(1'b1, 1'b0), O_BUSY, "md2_issue2");
    push(v_idle(), O_BUSY, "md2_busy", 8);
    push(v_idle(), O_NONE, "md2_idle");

    // Mul/div counter keeps running through a memory wait.
    push(v_md(1'b1, 1'b0), O_NONE, "mdm_issue");
    v = v_md(1'b0, 1'b1);
    v.req = 1'b1;
    push(v, O_MEMW | O_BUSY, "mdm_memw", 3);
    v.ack = 1'b1;
    push(v, O_ID | O_BUSY, "mdm_ack");
    push(v_md(1'b0, 1'b1), O_ID | O_BUSY, "mdm_stall", 3);
    push(v_md(1'b0, 1'b1), O_BUSY, "mdm_release");
    push(v_idle(), O_NONE, "mdm_idle");

    // Memory wait entered from LOAD_STALL resumes with one stall cycle left.
    push(v_ld(5'd3, 5'd3, 1'b1, 5'd0, 1'b0), O_ID, "lsm_detect");
    v = v_ld(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    v.req = 1'b1;
    push(v, O_MEMW, "lsm_memw");
    push(v_mem(1'b1, 1'b0), O_MEMW, "lsm_memw2");
    push(v_mem(1'b1, 1'b1), O_NONE, "lsm_ack");
    push(v_idle(), O_ID, "lsm_last");
    push(v_idle(), O_NONE, "lsm_run");

    // Reset: hazards on every input, yet all outputs held low.
    rst = 1'b1;
    v = v_ld(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    v.req = 1'b1; v.br = 1'b1; v.is_md = 1'b1;
    apply(v);
    @(negedge clk);
    check("reset_outputs", O_NONE);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i], vecs[i].exp, vecs[i].name);
    end

    // Bus timeout: 256 cycles with ack low sets the sticky flag.
    for (int i = 0; i < 256; i++) begin
      apply(v_mem(1'b1, 1'b0));
      @(negedge clk);
      if (i == 0 || i == 255) check($sformatf("to_wait_%0d", i), O_MEMW);
      @(posedge clk);
      #1;
    end
    cycle(v_mem(1'b1, 1'b0), O_MEMW | 8'h01, "to_set");
    cycle(v_mem(1'b1, 1'b1), 8'h01, "to_ack");
    cycle(v_idle(), 8'h01, "to_sticky");

    // Reset in the middle of a memory wait.
    cycle(v_mem(1'b1, 1'b0), O_MEMW | 8'h01, "rm_enter");
    cycle(v_mem(1'b1, 1'b0), O_MEMW | 8'h01, "rm_wait");
    #2;
    rst = 1'b1;
    #1;
    check("rm_rst_immediate", O_NONE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(v_ld(5'd3, 5'd3, 1'b1, 5'd0, 1'b0), O_ID, "rm_run_detect");
    cycle(v_idle(), O_ID, "rm_load_hold");
    cycle(v_idle(), O_NONE, "rm_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
